// File: rtl/clock_disp_pkg.sv
// Shared constants for the clock display path: digit width, blank code and channel map.
package clock_disp_pkg;

    localparam int          DIGIT_W         = 4;
    localparam logic [3:0]  DIGIT_BLANK     = 4'hF;

    localparam int          CH_TIME         = 0;
    localparam int          CH_ALARM        = 1;
    localparam int          CH_STOPWATCH    = 2;
    localparam int          CH_COUNT        = 3;

    localparam int          DEFAULT_TIMEOUT = 10;

    // Width needed to hold 0..max_val; never collapses to zero bits.
    function automatic int count_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector for a debounced button level; combinational press output.
// The history flop resets to 1 so a button held through reset never reads as a press.
module btn_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic btn_prev_d;
    logic btn_prev_q;

    always_comb begin
        btn_prev_d = btn;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q <= 1'b1;
        end else begin
            btn_prev_q <= btn_prev_d;
        end
    end

    assign press = btn & ~btn_prev_q;

endmodule

// File: rtl/display_source_mux.sv
// Registered display-source selector: button-cycled channel, auto-return to channel 0, set-mode blink.
// One cycle from MODE/SRC_BUS/SET_ACTIVE to Z and BLANK; no combinational input-to-output path.
module display_source_mux
    import clock_disp_pkg::*;
#(
    parameter int               WIDTH      = DIGIT_W,
    parameter int               NCH        = CH_COUNT,
    parameter int               TIMEOUT    = DEFAULT_TIMEOUT,
    parameter logic [WIDTH-1:0] BLANK_CODE = WIDTH'(DIGIT_BLANK)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   TICK,
    input  logic                   MODE_BTN,
    input  logic                   SET_ACTIVE,
    input  logic [NCH*WIDTH-1:0]   SRC_BUS,
    output logic [WIDTH-1:0]       Z,
    output logic [$clog2(NCH)-1:0] MODE,
    output logic                   BLANK
);

    localparam int              MW         = $clog2(NCH);
    localparam int              CW         = count_width(TIMEOUT);
    localparam bit              TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [MW-1:0]   MODE_LAST  = MW'(NCH - 1);

    logic             press;

    logic [MW-1:0]    mode_d,  mode_q;
    logic [CW-1:0]    cnt_d,   cnt_q;
    logic             phase_d, phase_q;
    logic [WIDTH-1:0] z_d,     z_q;
    logic             blank_d, blank_q;
    logic [WIDTH-1:0] sel_dat;

    btn_edge_det u_mode_btn (
        .clk   (CLK),
        .rst   (RST),
        .btn   (MODE_BTN),
        .press (press)
    );

    // Press outranks an expiring timeout: the channel advances from where it is.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (press) begin
            mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
            cnt_d  = '0;
        end else if (mode_q == '0) begin
            cnt_d  = '0;
        end else if (TICK && TIMEOUT_EN) begin
            if (cnt_q == CNT_LAST) begin
                mode_d = '0;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (!SET_ACTIVE || (mode_d != mode_q)) begin
            phase_d = 1'b0;
        end else if (TICK) begin
            phase_d = ~phase_q;
        end
    end

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            if (mode_q == MW'(k)) begin
                sel_dat = SRC_BUS[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        blank_d = phase_q & SET_ACTIVE;
        z_d     = blank_d ? BLANK_CODE : sel_dat;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            z_q     <= '0;
            blank_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            z_q     <= z_d;
            blank_q <= blank_d;
        end
    end

    assign Z     = z_q;
    assign MODE  = mode_q;
    assign BLANK = blank_q;

endmodule

// File: tb/tb_display_source_mux.sv
// Directed plus random bench for display_source_mux against a cycle-level behavioural model.
module tb_display_source_mux;

    localparam int WIDTH   = 4;
    localparam int NCH     = 3;
    localparam int TIMEOUT = 3;

    logic        clk = 1'b0;
    logic        rst, tick, btn, sa;
    logic [11:0] bus;
    logic [3:0]  z;
    logic [1:0]  mode;
    logic        blank;

    int checks = 0;
    int errors = 0;

    // Model state: channel, ticks since last press, blink phase, previous button level, outputs.
    int m_mode, m_cnt, m_phase, m_prev, m_z, m_blank;

    always #5 clk = ~clk;

    display_source_mux #(
        .WIDTH      (WIDTH),
        .NCH        (NCH),
        .TIMEOUT    (TIMEOUT),
        .BLANK_CODE (4'hF)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .TICK       (tick),
        .MODE_BTN   (btn),
        .SET_ACTIVE (sa),
        .SRC_BUS    (bus),
        .Z          (z),
        .MODE       (mode),
        .BLANK      (blank)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int press, old;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_phase = 0; m_z = 0; m_blank = 0; m_prev = 1;
        end else begin
            press   = (btn && m_prev == 0) ? 1 : 0;
            m_prev  = btn ? 1 : 0;
            m_blank = (m_phase == 1 && sa) ? 1 : 0;
            m_z     = (m_blank == 1) ? 15 : ((int'(bus) >> (4 * m_mode)) & 15);
            old     = m_mode;
            if (press == 1) begin
                m_mode = (m_mode + 1) % NCH;
                m_cnt  = 0;
            end else if (m_mode == 0) begin
                m_cnt = 0;
            end else if (tick) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == TIMEOUT) begin
                    m_mode = 0;
                    m_cnt  = 0;
                end
            end
            if (!sa || m_mode != old) m_phase = 0;
            else if (tick)            m_phase = 1 - m_phase;
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "_mode"},  32'(mode),  32'(m_mode));
        chk({tag, "_z"},     32'(z),     32'(m_z));
        chk({tag, "_blank"}, 32'(blank), 32'(m_blank));
    endtask

    task automatic press_once(input string tag);
        btn = 1'b1; cyc(tag);
        btn = 1'b0; cyc(tag);
    endtask

    initial begin
        int exp_mode [3] = '{1, 2, 0};
        int exp_z    [3] = '{'hB, 'h2, 'h4};
        int blink_z  [4] = '{'hF, 'h9, 'hF, 'h9};
        int blink_b  [4] = '{1, 0, 1, 0};

        rst = 1'b1; tick = 1'b0; btn = 1'b0; sa = 1'b0;
        bus = 12'h2B4;

        // Reset and select
        cyc("rst"); cyc("rst");
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_z",    32'(z),    32'd0);
        rst = 1'b0;
        cyc("rel");
        chk("rel_z", 32'(z), 32'h4);

        // Cycling and wrap with the button held several cycles
        for (int p = 0; p < 3; p++) begin
            btn = 1'b1;
            cyc("cyc");
            chk("cyc_mode", 32'(mode), 32'(exp_mode[p]));
            cyc("cyc");
            chk("cyc_z", 32'(z), 32'(exp_z[p]));
            cyc("cyc"); cyc("cyc"); cyc("cyc");
            chk("held_mode", 32'(mode), 32'(exp_mode[p]));
            btn = 1'b0;
            cyc("cyc"); cyc("cyc");
        end

        // Auto-return after TIMEOUT ticks
        press_once("ar"); press_once("ar");
        chk("ar_start", 32'(mode), 32'd2);
        for (int t = 1; t <= 3; t++) begin
            tick = 1'b1; cyc("ar");
            chk("ar_mode", 32'(mode), (t == 3) ? 32'd0 : 32'd2);
            tick = 1'b0; cyc("ar");
        end
        chk("ar_z", 32'(z), 32'h4);

        // Press on the 2nd tick wraps to 0
        press_once("ar2"); press_once("ar2");
        tick = 1'b1; cyc("ar2");
        tick = 1'b0; cyc("ar2");
        tick = 1'b1; btn = 1'b1; cyc("ar2");
        chk("ar2_mode", 32'(mode), 32'd0);
        tick = 1'b0; btn = 1'b0; cyc("ar2");

        // Collision: press with the expiring tick at MODE=1
        press_once("col");
        for (int t = 0; t < 2; t++) begin
            tick = 1'b1; cyc("col");
            tick = 1'b0; cyc("col");
        end
        tick = 1'b1; btn = 1'b1; cyc("col");
        chk("col_mode", 32'(mode), 32'd2);
        tick = 1'b0; btn = 1'b0; cyc("col");
        for (int t = 1; t <= 3; t++) begin
            tick = 1'b1; cyc("colcnt");
            chk("colcnt_mode", 32'(mode), (t == 3) ? 32'd0 : 32'd2);
            tick = 1'b0; cyc("colcnt");
        end

        // Blink at MODE=0
        bus = 12'h2B9; sa = 1'b1;
        cyc("blk");
        for (int t = 0; t < 4; t++) begin
            tick = 1'b1; cyc("blk");
            tick = 1'b0; cyc("blk");
            chk("blk_z",     32'(z),     32'(blink_z[t]));
            chk("blk_blank", 32'(blank), 32'(blink_b[t]));
        end
        tick = 1'b1; cyc("blk");
        tick = 1'b0; cyc("blk");
        sa = 1'b0; cyc("blkdrop");
        chk("drop_z",     32'(z),     32'h9);
        chk("drop_blank", 32'(blank), 32'd0);

        // Reset mid-operation with button held
        press_once("mid"); press_once("mid");
        sa = 1'b1;
        tick = 1'b1; cyc("mid");
        tick = 1'b0; cyc("mid");
        chk("mid_blank_on", 32'(blank), 32'd1);
        chk("mid_mode2",    32'(mode),  32'd2);
        btn = 1'b1; rst = 1'b1; cyc("midrst");
        chk("midrst_mode",  32'(mode),  32'd0);
        chk("midrst_z",     32'(z),     32'd0);
        chk("midrst_blank", 32'(blank), 32'd0);
        rst = 1'b0;
        cyc("post"); cyc("post"); cyc("post");
        chk("post_hold_mode", 32'(mode), 32'd0);
        btn = 1'b0; cyc("post");
        btn = 1'b1; cyc("post");
        chk("post_press_mode", 32'(mode), 32'd1);
        btn = 1'b0; sa = 1'b0; cyc("post");

        // Randomized stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            rst  = ($urandom_range(63) == 0);
            tick = ($urandom_range(3) == 0);
            if ($urandom_range(4) == 0) btn = ~btn;
            if ($urandom_range(7) == 0) sa  = ~sa;
            if ($urandom_range(15) == 0) bus = 12'($urandom);
            cyc("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_source_mux.md
# display_source_mux

Parametrised, registered display-source selector for the digital clock. It replaces the fixed three-way combinational select with an internal mode register that cycles through NCH digit sources (time, alarm, stopwatch, …) on a front-panel button. It also returns automatically to the time source after a timeout and blinks the digit while a set operation is active. It sits between the per-function digit counters and the 7-segment decoder.

## Interface

Parameters:
- WIDTH, 4, bits per displayed digit
- NCH, 3, number of source channels (≥2); channel 0 is the home (time) source
- TIMEOUT, 10, TICK periods without a button press before auto-return to channel 0; 0 disables auto-return
- BLANK_CODE, 4'hF, digit code driven during the blink-off phase (decoder renders it dark)

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  synchronous, active-high reset
- TICK  in  1  one-cycle enable pulse, nominally 1 Hz, drives blink and timeout
- MODE_BTN  in  1  debounced level from the mode button; each rising edge advances the channel
- SET_ACTIVE  in  1  high while the user is editing; enables blink
- SRC_BUS  in  NCH*WIDTH  channel k = SRC_BUS[k*WIDTH +: WIDTH]
- Z  out  WIDTH  registered displayed digit
- MODE  out  $clog2(NCH)  current channel index
- BLANK  out  1  registered; high when Z carries BLANK_CODE because of blink

## Operation

- Edge detect: btn_prev <= MODE_BTN; press = MODE_BTN & ~btn_prev. btn_prev resets to 1, so a button held through reset does not count as a press.
- Mode register: on press, MODE <= (MODE == NCH-1) ? 0 : MODE+1 (wraps).
- Timeout counter, width $clog2(TIMEOUT+1):
  - Cleared on press, and while MODE == 0.
  - Otherwise increments on TICK.
  - When it reaches TIMEOUT with TICK high, MODE <= 0 and the counter clears.
- Press and timeout expiry in the same cycle: the press wins. MODE advances from its current value and the counter clears.
- Blink phase:
  - Toggles on TICK while SET_ACTIVE = 1.
  - Forced to 0 when SET_ACTIVE = 0 or when MODE changes.
- Output register:
  - Z <= (phase & SET_ACTIVE) ? BLANK_CODE : selected channel.
  - BLANK <= phase & SET_ACTIVE.
- Reset values: MODE = 0, counter = 0, phase = 0, Z = 0, BLANK = 0.
- Reset mid-operation (any state): all of the above on the next edge; no press is generated on exit from reset.

## Timing

- Press (MODE_BTN rises) sampled at edge n: MODE updates at edge n; Z and BLANK show the new channel at edge n+1.
- SRC_BUS change: visible on Z one cycle later (1-cycle latency, no combinational path from inputs to outputs).
- Auto-return:
  - With MODE ≠ 0, the TIMEOUT-th TICK after the last press sets MODE = 0 at that edge.
  - Z shows channel 0 one cycle later.
- Blink:
  - First TICK with SET_ACTIVE high sets phase = 1; Z = BLANK_CODE one cycle later.
  - Period is 2 TICKs.
- Holding MODE_BTN high advances exactly once.

## Structure

- Shared package clock_disp_pkg:
  - DIGIT_W = 4, DIGIT_BLANK = 4'hF.
  - Channel constants CH_TIME = 0, CH_ALARM = 1, CH_STOPWATCH = 2.
  - Default TIMEOUT.
- One sub-module, btn_edge_det: the rising-edge detector with reset value 1. It is reusable for the set/adjust buttons.
- Top level holds the mode register, timeout counter, blink phase and output register. The channel select is a generic indexed part-select over SRC_BUS.

## Test plan

- Reset/select: RST=1 for 2 cycles, then SRC_BUS = {4'h2, 4'hB, 4'h4} (NCH=3). Required: Z=0 and MODE=0 during reset; Z=4'h4 one cycle after release.
- Cycling and wrap: three MODE_BTN presses, each held 5 cycles, with the SRC_BUS above. Required: MODE = 1, 2, 0; Z = 4'hB, 4'h2, 4'h4, each one cycle after its MODE change; the held level gives no extra advances.
- Auto-return with TIMEOUT=3: press to MODE=2, then 3 TICKs with no press. Required: MODE=0 on the 3rd TICK edge; Z=4'h4 one cycle later. A 2nd-TICK press instead gives MODE=0 via wrap and clears the counter.
- Collision: press and the expiring TICK in the same cycle at MODE=1. Required: MODE=2, counter=0.
- Blink: SET_ACTIVE=1 at MODE=0 with TIM=4'h9, then 4 TICKs. Required: Z alternates F, 9, F, 9 with BLANK 1, 0, 1, 0. Dropping SET_ACTIVE mid-phase gives Z=4'h9 and BLANK=0 next cycle.
- Reset mid-operation: RST during blink-on at MODE=2 with MODE_BTN held high. Required: all outputs 0 next edge; no advance after release until MODE_BTN falls and rises again.
